alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX issue stage directly upstream of the execute-stage ALU.
- Accepts one RV32I instruction per cycle, together with its PC and register-file read data, and decodes the ALU-class opcodes.
- Registers opA, opB, aluOutSel, rd and rd_we for the ALU and writeback.
- Holds its outputs under downstream back-pressure and clears on pipeline flush.

Parameters:
XLEN, 32, datapath width of pc, rs1_data, rs2_data, opA, opB.
PASS_SEL, 4'b1111, aluOutSel code for pass-through of opA; also issued for LUI and illegal instructions.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
flush  in  1  drops the held entry and blocks capture this cycle.
in_valid  in  1  instr/pc/rs1_data/rs2_data are valid.
in_ready  out  1  stage can accept an instruction this cycle.
instr  in  32  raw RV32I instruction word.
pc  in  XLEN  PC of instr.
rs1_data  in  XLEN  register-file read of rs1.
rs2_data  in  XLEN  register-file read of rs2.
out_valid  out  1  outputs hold a decoded operation.
out_ready  in  1  ALU/EX consumes the entry this cycle.
opA  out  XLEN  ALU operand A.
opB  out  XLEN  ALU operand B.
aluOutSel  out  4  ALU op: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1111 pass opA.
rd  out  5  destination register.
rd_we  out  1  writeback enable.
illegal  out  1  held entry is not a supported instruction.

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n); all state updates on the rising edge.
- Reset values: out_valid=0, opA=0, opB=0, aluOutSel=PASS_SEL, rd=0, rd_we=0, illegal=0.
- State machine has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !out_valid || out_ready. This is combinational; there is no skid buffer.
- Capture occurs when in_valid && in_ready && !flush. The decoded entry appears on the outputs the next cycle (latency 1). The state is FULL afterward.
- Transitions:
  - FULL with out_ready=1 and no capture → EMPTY.
  - FULL with out_ready=1 and a capture → stays FULL with the new entry (back-to-back, 1 op/cycle).
- While out_valid && !out_ready, every output is held bit-stable.
- flush=1 → next cycle EMPTY, regardless of in_valid or out_ready. Flush wins over a simultaneous capture.
- rst_n=0 mid-operation → reset values next edge. Any held entry is lost.
- Decode by opcode (instr[6:0]):
  - OP 0110011: opA=rs1_data, opB=rs2_data. funct3 mapping:
    - 000: add, or sub when funct7=0100000.
    - 001: sll; 010: slt; 011: sltu; 100: xor.
    - 101: srl, or sra when funct7=0100000.
    - 110: or; 111: and.
    - funct7 must be 0000000, or 0100000 only for 000/101; anything else is illegal.
  - OP-IMM 0010011: opA=rs1_data, opB=sign-extended instr[31:20]. Same funct3 mapping, but 000 is always add.
  - Immediate shifts (001, 101): opB={27'b0, instr[24:20]}. instr[31:25] must be 0000000 (0100000 allowed only for srai); otherwise illegal.
  - LUI 0110111: opA={instr[31:12],12'b0}, opB=0, sel=PASS_SEL.
  - AUIPC 0010111: opA=pc, opB={instr[31:12],12'b0}, sel=0000.
  - Any other opcode: illegal.
- Register shifts: opB is masked to {27'b0, rs2_data[4:0]}. The ALU iterates opB times, so opB never exceeds 31 for any shift.
- Illegal entries:
  - Still produce out_valid=1 with illegal=1.
  - Outputs: opA=0, opB=0, aluOutSel=PASS_SEL, rd_we=0.
- rd = instr[11:7]. rd_we = !illegal && rd!=0.
- Arithmetic is width-exact. Immediates are sign- or zero-extended to XLEN; there is no truncation beyond the shamt mask.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, in_valid=1 → out_valid=0, aluOutSel=1111, in_ready=1. The first capture happens only after rst_n=1.
2. SUB x3,x1,x2 (0x402081B3) with rs1=10, rs2=3 → next cycle opA=10, opB=3, sel=0001, rd=3, rd_we=1. ADDI x5,x0,-1 (0xFFF00293) → opB=0xFFFFFFFF, sel=0000.
3. SRA x4,x1,x2 with rs2_data=0x00000123 → opB=0x00000003, sel=1001. SRAI with instr[31:25]=0000001 → illegal=1, rd_we=0, sel=1111.
4. LUI x7,0x12345 → opA=0x12345000, sel=1111. AUIPC x8,0x1 at pc=0x100 → opA=0x100, opB=0x1000, sel=0000.
5. Back-pressure: capture ADD, then out_ready=0 for 3 cycles with new instrs offered → outputs stable and in_ready=0. Then out_ready=1 → next instr captured the same cycle and appears the following cycle.
6. flush=1 together with in_valid=1 while FULL → next cycle out_valid=0 and nothing captured. Also x0 destination (ADD x0,x1,x2) → rd_we=0, illegal=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I ALU-class instructions and registers
// operands, ALU select, destination and writeback enable for the execute
// stage. Valid/ready handshake with a one-entry output register, no skid.
module alu_issue_stage #(
   parameter int          XLEN     = 32,
   parameter logic [3:0]  PASS_SEL = 4'b1111
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] opA,
   output logic [XLEN-1:0] opB,
   output logic [3:0]      aluOutSel,
   output logic [4:0]      rd,
   output logic            rd_we,
   output logic            illegal
);

   typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_capture;

   logic [XLEN-1:0]   r_opa, r_opb;
   logic [3:0]        r_sel;
   logic [4:0]        r_rd;
   logic              r_rd_we, r_illegal;

   logic [6:0]        w_opcode, w_funct7;
   logic [2:0]        w_funct3;
   logic [4:0]        w_rd;
   logic [XLEN-1:0]   w_imm_i, w_imm_u, w_shamt_i, w_shamt_r;
   logic [XLEN-1:0]   w_opa, w_opb;
   logic [3:0]        w_sel;
   logic              w_illegal, w_rd_we;

   assign w_opcode  = instr[6:0];
   assign w_rd      = instr[11:7];
   assign w_funct3  = instr[14:12];
   assign w_funct7  = instr[31:25];
   assign w_imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign w_imm_u   = XLEN'($signed({instr[31:12], 12'b0}));
   assign w_shamt_i = {{(XLEN-5){1'b0}}, instr[24:20]};
   // The ALU iterates opB times for shifts, so register shift amounts are masked to 0..31.
   assign w_shamt_r = {{(XLEN-5){1'b0}}, rs2_data[4:0]};

   // No skid buffer: accept only when empty or the held entry leaves this cycle.
   assign in_ready  = (r_state == ST_EMPTY) || out_ready;
   assign w_capture = in_valid && in_ready && !flush;

   assign out_valid = (r_state == ST_FULL);
   assign opA       = r_opa;
   assign opB       = r_opb;
   assign aluOutSel = r_sel;
   assign rd        = r_rd;
   assign rd_we     = r_rd_we;
   assign illegal   = r_illegal;

   // Next-state logic: flush dominates, then capture, then drain.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else if (w_capture) begin
         w_state_nxt = ST_FULL;
      end else if ((r_state == ST_FULL) && out_ready) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Instruction decode into operands, ALU select and legality.
   always_comb begin
      w_illegal = 1'b0;
      w_opa     = rs1_data;
      w_opb     = rs2_data;
      w_sel     = PASS_SEL;
      w_rd_we   = 1'b0;
      case (w_opcode)
         7'b0110011: begin
            if ((w_funct7 == 7'b0000000) ||
                ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))) begin
               w_illegal = 1'b0;
            end else begin
               w_illegal = 1'b1;
            end
            case (w_funct3)
               3'b000:  w_sel = w_funct7[5] ? 4'b0001 : 4'b0000;
               3'b001:  begin w_sel = 4'b0111; w_opb = w_shamt_r; end
               3'b010:  w_sel = 4'b0101;
               3'b011:  w_sel = 4'b0110;
               3'b100:  w_sel = 4'b0010;
               3'b101:  begin w_sel = w_funct7[5] ? 4'b1001 : 4'b1000; w_opb = w_shamt_r; end
               3'b110:  w_sel = 4'b0011;
               default: w_sel = 4'b0100;
            endcase
         end
         7'b0010011: begin
            w_opb = w_imm_i;
            case (w_funct3)
               3'b000:  w_sel = 4'b0000;
               3'b001: begin
                  w_sel = 4'b0111;
                  w_opb = w_shamt_i;
                  if (w_funct7 == 7'b0000000) begin
                     w_illegal = 1'b0;
                  end else begin
                     w_illegal = 1'b1;
                  end
               end
               3'b010:  w_sel = 4'b0101;
               3'b011:  w_sel = 4'b0110;
               3'b100:  w_sel = 4'b0010;
               3'b101: begin
                  w_opb = w_shamt_i;
                  if (w_funct7 == 7'b0000000) begin
                     w_sel = 4'b1000;
                  end else if (w_funct7 == 7'b0100000) begin
                     w_sel = 4'b1001;
                  end else begin
                     w_illegal = 1'b1;
                  end
               end
               3'b110:  w_sel = 4'b0011;
               default: w_sel = 4'b0100;
            endcase
         end
         7'b0110111: begin
            w_opa = w_imm_u;
            w_opb = {XLEN{1'b0}};
            w_sel = PASS_SEL;
         end
         7'b0010111: begin
            w_opa = pc;
            w_opb = w_imm_u;
            w_sel = 4'b0000;
         end
         default: w_illegal = 1'b1;
      endcase
      // Illegal entries still travel down the pipe, but as a harmless pass of zero.
      if (w_illegal) begin
         w_opa   = {XLEN{1'b0}};
         w_opb   = {XLEN{1'b0}};
         w_sel   = PASS_SEL;
         w_rd_we = 1'b0;
      end else begin
         w_rd_we = (w_rd != 5'd0);
      end
   end

   // State and output registers: load on capture, otherwise hold bit-stable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_EMPTY;
         r_opa     <= {XLEN{1'b0}};
         r_opb     <= {XLEN{1'b0}};
         r_sel     <= PASS_SEL;
         r_rd      <= 5'd0;
         r_rd_we   <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_opa     <= w_opa;
            r_opb     <= w_opb;
            r_sel     <= w_sel;
            r_rd      <= w_rd;
            r_rd_we   <= w_rd_we;
            r_illegal <= w_illegal;
         end else begin
            r_opa     <= r_opa;
            r_opb     <= r_opb;
            r_sel     <= r_sel;
            r_rd      <= r_rd;
            r_rd_we   <= r_rd_we;
            r_illegal <= r_illegal;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural reference model.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instr, pc, rs1_data, rs2_data, opA, opB;
   logic [3:0]  aluOutSel;
   logic [4:0]  rd;
   logic        rd_we, illegal;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  sel;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t m_ent;
   logic m_valid = 1'b0;
   logic m_known = 1'b0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .opA(opA), .opB(opB),
      .aluOutSel(aluOutSel), .rd(rd), .rd_we(rd_we), .illegal(illegal)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference decode written from the ISA tables: funct3 indexes an op list,
   // the alternate funct7 bumps add->sub and srl->sra.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                       input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      int unsigned base_sel [8] = '{0, 7, 5, 6, 2, 8, 3, 4};
      int unsigned op = ins[6:0];
      int unsigned f3 = ins[14:12];
      int unsigned f7 = ins[31:25];
      bit is_shift = (f3 == 1) || (f3 == 5);
      e.ill = 1'b1; e.a = 32'd0; e.b = 32'd0; e.sel = 4'd15;
      e.rd  = ins[11:7];
      if (op == 'h33) begin
         e.ill = !((f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
         e.a   = r1;
         e.b   = is_shift ? (r2 % 32) : r2;
         e.sel = 4'(base_sel[f3] + ((f7 == 'h20) ? 1 : 0));
      end else if (op == 'h13) begin
         e.ill = is_shift && !((f7 == 0) || (f3 == 5 && f7 == 'h20));
         e.a   = r1;
         e.b   = is_shift ? ((ins >> 20) % 32) : 32'($signed(ins) >>> 20);
         e.sel = 4'(base_sel[f3] + ((f3 == 5 && f7 == 'h20) ? 1 : 0));
      end else if (op == 'h37) begin
         e.ill = 1'b0; e.a = ins & 32'hFFFFF000; e.b = 32'd0; e.sel = 4'd15;
      end else if (op == 'h17) begin
         e.ill = 1'b0; e.a = p; e.b = ins & 32'hFFFFF000; e.sel = 4'd0;
      end
      if (e.ill) begin
         e.a = 32'd0; e.b = 32'd0; e.sel = 4'd15;
      end
      e.we = !e.ill && (e.rd != 0);
      return e;
   endfunction

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic tick();
      logic exp_rdy, cap;
      exp_t nxt;
      #1;
      exp_rdy = !m_valid || out_ready;
      if (m_known) check_eq("in_ready", in_ready, exp_rdy);
      cap = rst_n && in_valid && exp_rdy && !flush;
      nxt = ref_decode(instr, pc, rs1_data, rs2_data);
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1'b0; m_known = 1'b1;
         m_ent   = '{a: 32'd0, b: 32'd0, sel: 4'd15, rd: 5'd0, we: 1'b0, ill: 1'b0};
      end else if (cap) begin
         m_valid = 1'b1; m_ent = nxt;
      end else if (flush || out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      if (m_known) check_eq("out_valid", out_valid, m_valid);
      if (m_valid || !rst_n) begin
         check_eq("opA", opA, m_ent.a);
         check_eq("opB", opB, m_ent.b);
         check_eq("sel", aluOutSel, m_ent.sel);
         check_eq("rd", rd, m_ent.rd);
         check_eq("rd_we", rd_we, m_ent.we);
         check_eq("illegal", illegal, m_ent.ill);
      end
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
      in_valid = 1'b1; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      offer(32'h002081B3, 32'h0, 32'd1, 32'd2);

      // Reset held two cycles with in_valid asserted.
      tick(); tick();
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_sel", aluOutSel, 4'b1111);
      check_eq("rst_opA", opA, 32'd0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      offer(32'h402081B3, 32'h0, 32'd10, 32'd3);           // SUB x3,x1,x2
      tick();
      check_eq("sub_valid", out_valid, 1'b1);
      check_eq("sub_opA", opA, 32'd10);
      check_eq("sub_opB", opB, 32'd3);
      check_eq("sub_sel", aluOutSel, 4'b0001);
      check_eq("sub_rd", rd, 5'd3);
      check_eq("sub_we", rd_we, 1'b1);
      offer(32'hFFF00293, 32'h0, 32'd0, 32'd0);            // ADDI x5,x0,-1
      tick();
      check_eq("addi_opB", opB, 32'hFFFFFFFF);
      check_eq("addi_sel", aluOutSel, 4'b0000);
      offer(32'h4020D233, 32'h0, 32'd7, 32'h00000123);     // SRA x4,x1,x2
      tick();
      check_eq("sra_opB", opB, 32'h00000003);
      check_eq("sra_sel", aluOutSel, 4'b1001);
      offer(32'h0230D213, 32'h0, 32'd7, 32'd0);            // SRAI with bad funct7
      tick();
      check_eq("srai_ill", illegal, 1'b1);
      check_eq("srai_we", rd_we, 1'b0);
      check_eq("srai_sel", aluOutSel, 4'b1111);
      offer(32'h123453B7, 32'h0, 32'd9, 32'd9);            // LUI x7,0x12345
      tick();
      check_eq("lui_opA", opA, 32'h12345000);
      check_eq("lui_sel", aluOutSel, 4'b1111);
      offer(32'h00001417, 32'h100, 32'd9, 32'd9);          // AUIPC x8,0x1
      tick();
      check_eq("auipc_opA", opA, 32'h100);
      check_eq("auipc_opB", opB, 32'h1000);
      check_eq("auipc_sel", aluOutSel, 4'b0000);

      // Back-pressure: hold for three cycles while new instructions are offered.
      offer(32'h002081B3, 32'h0, 32'd5, 32'd7);            // ADD x3,x1,x2
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(32'h402081B3, 32'h0, 32'd100 + 32'(i), 32'd1);
         #1 check_eq("bp_in_ready", in_ready, 1'b0);
         tick();
         check_eq("bp_opA", opA, 32'd5);
         check_eq("bp_opB", opB, 32'd7);
         check_eq("bp_sel", aluOutSel, 4'b0000);
      end
      out_ready = 1'b1;
      #1 check_eq("bp_release_ready", in_ready, 1'b1);
      tick();
      check_eq("bp_new_opA", opA, 32'd102);
      check_eq("bp_new_sel", aluOutSel, 4'b0001);

      // Flush while FULL with a simultaneous offer.
      flush = 1'b1;
      offer(32'h002081B3, 32'h0, 32'd55, 32'd66);
      tick();
      check_eq("flush_valid", out_valid, 1'b0);
      flush = 1'b0;
      offer(32'h00208033, 32'h0, 32'd1, 32'd2);            // ADD x0,x1,x2
      tick();
      check_eq("x0_we", rd_we, 1'b0);
      check_eq("x0_ill", illegal, 1'b0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] ins;
         logic [6:0]  ops [5] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h00};
         int unsigned k = $urandom_range(0, 4);
         ins = $urandom;
         ins[6:0] = (k == 4) ? 7'($urandom) : ops[k];
         case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            default: ins[31:25] = ins[31:25];
         endcase
         offer(ins, $urandom, $urandom, $urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 9) == 0);
         rst_n     = ($urandom_range(0, 49) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
